alu_instr_sequencer: RTL and testbench

Hardwired control sequencer that replaces hand-driven bench strobes for register-register ALU instructions on the bus-based datapath. It runs the fetch phase (T0-T2), decodes the IR, and issues per-cycle bus-drive/latch strobes for execute (T3-T6). Generalised over register count, field widths, memory-wait tolerance and instruction class: three-operand, unary, and HI/LO-writing mul/div. Sits beside Datapath and drives its R_rd/R_wrt, *_out, *_rd, IncPC, Read and op_sel inputs.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_instr_sequencer_if.sv | 31 +++
 rtl/alu_seq_decode.sv | 43 ++++
 rtl/alu_instr_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcodes, FSM state
// encoding, instruction classes and the opcode classifier.
package alu_seq_pkg;

  localparam logic [31:0] OP_ADD = 32'h03;
  localparam logic [31:0] OP_SUB = 32'h04;
  localparam logic [31:0] OP_AND = 32'h05;
  localparam logic [31:0] OP_OR  = 32'h06;
  localparam logic [31:0] OP_MUL = 32'h0F;
  localparam logic [31:0] OP_DIV = 32'h10;
  localparam logic [31:0] OP_NEG = 32'h11;
  localparam logic [31:0] OP_NOT = 32'h12;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  // CLS_ILLEGAL is encoding 0 so a cleared class register reads as "nothing"
  typedef enum logic [1:0] {
    CLS_ILLEGAL, CLS_THREE, CLS_MULDIV, CLS_UNARY
  } cls_t;

  // Opcode is passed zero-extended so the function is independent of OPC_W
  function automatic cls_t classify(input logic [31:0] op);
    cls_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: c = CLS_THREE;
      OP_MUL, OP_DIV:                c = CLS_MULDIV;
      OP_NEG, OP_NOT:                c = CLS_UNARY;
      default:                       c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface alu_instr_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
);
  logic                start;
  logic [DATA_W-1:0]   ir;
  logic                mem_ready;
  logic [NUM_REGS-1:0] r_in;
  logic [NUM_REGS-1:0] r_out;
  logic                pc_out, mdr_out, zlo_out, zhi_out;
  logic                mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
  logic                inc_pc, read;
  logic [OPC_W-1:0]    alu_op;
  logic                busy, done, illegal, mem_fault;

  modport master (
    input  start, ir, mem_ready,
    output r_in, r_out, pc_out, mdr_out, zlo_out, zhi_out,
           mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
           inc_pc, read, alu_op, busy, done, illegal, mem_fault
  );

  modport slave (
    output start, ir, mem_ready,
    input  r_in, r_out, pc_out, mdr_out, zlo_out, zhi_out,
           mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in,
           inc_pc, read, alu_op, busy, done, illegal, mem_fault
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational IR decoder: splits opcode/Ra/Rb/Rc, classifies the opcode,
// rejects register indices beyond NUM_REGS and expands Ra/Rb to one-hot.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5,
  parameter int FIELD_W  = 4
) (
  input  logic [DATA_W-1:0]   ir,
  output cls_t                cls,
  output logic [OPC_W-1:0]    op,
  output logic [FIELD_W-1:0]  ra,
  output logic [FIELD_W-1:0]  rb,
  output logic [FIELD_W-1:0]  rc,
  output logic [NUM_REGS-1:0] ra_hot,
  output logic [NUM_REGS-1:0] rb_hot
);
  cls_t base;
  logic ra_ok, rb_ok, rc_ok, range_ok;
  logic unused_low_bits;

  assign op = ir[DATA_W-1 -: OPC_W];
  assign ra = ir[DATA_W-OPC_W-1 -: FIELD_W];
  assign rb = ir[DATA_W-OPC_W-FIELD_W-1 -: FIELD_W];
  assign rc = ir[DATA_W-OPC_W-2*FIELD_W-1 -: FIELD_W];
  assign unused_low_bits = ^ir[DATA_W-OPC_W-3*FIELD_W-1:0];

  assign ra_hot = NUM_REGS'(1) << ra;
  assign rb_hot = NUM_REGS'(1) << rb;

  // Class from opcode, downgraded to illegal if a field this class uses is out of range
  always_comb begin
    base     = classify(32'(op));
    ra_ok    = 32'(ra) < 32'(NUM_REGS);
    rb_ok    = 32'(rb) < 32'(NUM_REGS);
    rc_ok    = 32'(rc) < 32'(NUM_REGS);
    range_ok = ra_ok && rb_ok && ((base != CLS_THREE) || rc_ok);
    cls      = range_ok ? base : CLS_ILLEGAL;
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/decode/execute sequencer for register-register ALU
// instructions on the single-bus datapath. Outputs are Moore except T3,
// which decodes the IR directly; fields captured at the end of T3 drive T4-T6.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int FIELD_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   clr,
  alu_instr_sequencer_if.master bus
);
  localparam int                  CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    TMO   = CNT_W'(MEM_TIMEOUT);
  localparam logic [NUM_REGS-1:0] ONE   = NUM_REGS'(1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  cls_t                 cls_q;
  logic [OPC_W-1:0]     op_q;
  logic [FIELD_W-1:0]   ra_q, rb_q, rc_q;

  cls_t                 dec_cls;
  logic [OPC_W-1:0]     dec_op;
  logic [FIELD_W-1:0]   dec_ra, dec_rb, dec_rc;
  logic [NUM_REGS-1:0]  dec_ra_hot, dec_rb_hot;

  alu_seq_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .OPC_W    (OPC_W),
    .FIELD_W  (FIELD_W)
  ) u_decode (
    .ir     (bus.ir),
    .cls    (dec_cls),
    .op     (dec_op),
    .ra     (dec_ra),
    .rb     (dec_rb),
    .rc     (dec_rc),
    .ra_hot (dec_ra_hot),
    .rb_hot (dec_rb_hot)
  );

  // State, memory-wait counter and the instruction fields captured as T3 ends
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      cnt   <= '0;
      cls_q <= CLS_ILLEGAL;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_T3) begin
        cls_q <= dec_cls;
        op_q  <= dec_op;
        ra_q  <= dec_ra;
        rb_q  <= dec_rb;
        rc_q  <= dec_rc;
      end
    end
  end

  // Next state and per-cycle strobes; every strobe defaults low
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.r_in      = '0;
    bus.r_out     = '0;
    bus.pc_out    = 1'b0;
    bus.mdr_out   = 1'b0;
    bus.zlo_out   = 1'b0;
    bus.zhi_out   = 1'b0;
    bus.mar_in    = 1'b0;
    bus.mdr_in    = 1'b0;
    bus.ir_in     = 1'b0;
    bus.y_in      = 1'b0;
    bus.z_in      = 1'b0;
    bus.hi_in     = 1'b0;
    bus.lo_in     = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.read      = 1'b0;
    bus.alu_op    = '0;
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    bus.illegal   = 1'b0;
    bus.mem_fault = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_T0;
      S_T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
        cnt_nxt    = '0;
        state_nxt  = S_T1;
      end
      S_T1: begin
        if ((MEM_TIMEOUT != 0) && (cnt == TMO)) begin
          bus.mem_fault = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = S_IDLE;
        end else begin
          bus.read   = 1'b1;
          bus.mdr_in = 1'b1;
          if (bus.mem_ready) begin
            cnt_nxt   = '0;
            state_nxt = S_T2;
          end else if (MEM_TIMEOUT != 0) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
        state_nxt   = S_T3;
      end
      S_T3: begin
        state_nxt = S_T4;
        case (dec_cls)
          CLS_THREE: begin
            bus.r_out = dec_rb_hot;
            bus.y_in  = 1'b1;
          end
          CLS_MULDIV: begin
            bus.r_out = dec_ra_hot;
            bus.y_in  = 1'b1;
          end
          CLS_UNARY: begin
            bus.r_out  = dec_rb_hot;
            bus.alu_op = dec_op;
            bus.z_in   = 1'b1;
          end
          default: begin
            bus.illegal = 1'b1;
            state_nxt   = S_IDLE;
          end
        endcase
      end
      S_T4: begin
        state_nxt = S_T5;
        case (cls_q)
          CLS_THREE: begin
            bus.r_out  = ONE << rc_q;
            bus.alu_op = op_q;
            bus.z_in   = 1'b1;
          end
          CLS_MULDIV: begin
            bus.r_out  = ONE << rb_q;
            bus.alu_op = op_q;
            bus.z_in   = 1'b1;
          end
          CLS_UNARY: begin
            bus.zlo_out = 1'b1;
            bus.r_in    = ONE << ra_q;
            bus.done    = 1'b1;
            state_nxt   = bus.start ? S_T0 : S_IDLE;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CLS_THREE: begin
            bus.zlo_out = 1'b1;
            bus.r_in    = ONE << ra_q;
            bus.done    = 1'b1;
            state_nxt   = bus.start ? S_T0 : S_IDLE;
          end
          CLS_MULDIV: begin
            bus.zlo_out = 1'b1;
            bus.lo_in   = 1'b1;
            state_nxt   = S_T6;
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      S_T6: begin
        bus.zhi_out = 1'b1;
        bus.hi_in   = 1'b1;
        bus.done    = 1'b1;
        state_nxt   = bus.start ? S_T0 : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: a 16-register and an 8-register instance
// share one stimulus stream and are compared cycle by cycle against a
// reference that expands each instruction into its expected strobe sequence.
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic pc_out, mdr_out, zlo_out, zhi_out;
    logic mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic inc_pc, read, busy, done, illegal, mem_fault;
    logic [4:0]  alu_op;
    logic [15:0] r_in;
    logic [15:0] r_out;
  } obs_t;
  typedef obs_t obs_q_t[$];

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  logic        mem_ready = 1'b0;
  int          checks = 0;
  int          errors = 0;
  obs_t        o16, o8;
  obs_t        zero = '0;

  always #5 clk = ~clk;

  alu_instr_sequencer_if #(.DATA_W(32), .NUM_REGS(16), .OPC_W(5)) bus16();
  alu_instr_sequencer_if #(.DATA_W(32), .NUM_REGS(8),  .OPC_W(5)) bus8();

  assign bus16.start = start;
  assign bus16.ir = ir;
  assign bus16.mem_ready = mem_ready;
  assign bus8.start = start;
  assign bus8.ir = ir;
  assign bus8.mem_ready = mem_ready;

  alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(16), .OPC_W(5), .FIELD_W(4), .MEM_TIMEOUT(15))
    dut16 (.clk(clk), .clr(clr), .bus(bus16));
  alu_instr_sequencer #(.DATA_W(32), .NUM_REGS(8), .OPC_W(5), .FIELD_W(4), .MEM_TIMEOUT(15))
    dut8 (.clk(clk), .clr(clr), .bus(bus8));

  assign o16 = {bus16.pc_out, bus16.mdr_out, bus16.zlo_out, bus16.zhi_out,
                bus16.mar_in, bus16.mdr_in, bus16.ir_in, bus16.y_in, bus16.z_in, bus16.hi_in, bus16.lo_in,
                bus16.inc_pc, bus16.read, bus16.busy, bus16.done, bus16.illegal, bus16.mem_fault,
                bus16.alu_op, bus16.r_in, bus16.r_out};
  assign o8  = {bus8.pc_out, bus8.mdr_out, bus8.zlo_out, bus8.zhi_out,
                bus8.mar_in, bus8.mdr_in, bus8.ir_in, bus8.y_in, bus8.z_in, bus8.hi_in, bus8.lo_in,
                bus8.inc_pc, bus8.read, bus8.busy, bus8.done, bus8.illegal, bus8.mem_fault,
                bus8.alu_op, 8'h00, bus8.r_in, 8'h00, bus8.r_out};

  // At most one bus driver in any cycle, on both instances
  always @(negedge clk) begin
    if (clr) begin
      checks += 2;
      if ($countones({bus16.pc_out, bus16.mdr_out, bus16.zlo_out, bus16.zhi_out, bus16.r_out}) > 1) begin
        errors++;
        $display("FAIL one_driver dut16 t=%0t r_out=%h", $time, bus16.r_out);
      end
      if ($countones({bus8.pc_out, bus8.mdr_out, bus8.zlo_out, bus8.zhi_out, bus8.r_out}) > 1) begin
        errors++;
        $display("FAIL one_driver dut8 t=%0t r_out=%h", $time, bus8.r_out);
      end
    end
  end

  function automatic obs_t blank();
    obs_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // Expected cycle-by-cycle outputs from T0 onward, plus one trailing idle cycle
  function automatic obs_q_t build(input logic [31:0] instr, input int nregs, input int waits);
    obs_q_t q;
    obs_t   e;
    int     op, ra, rb, rc, nread;
    bit     three, md, un, legal;
    op = int'(instr[31:27]);
    ra = int'(instr[26:23]);
    rb = int'(instr[22:19]);
    rc = int'(instr[18:15]);
    e = blank(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; q.push_back(e);
    nread = (waits >= TMO) ? TMO : waits + 1;
    for (int i = 0; i < nread; i++) begin
      e = blank(); e.read = 1; e.mdr_in = 1; q.push_back(e);
    end
    if (waits >= TMO) begin
      e = blank(); e.mem_fault = 1; q.push_back(e);
      q.push_back(zero);
      return q;
    end
    e = blank(); e.mdr_out = 1; e.ir_in = 1; q.push_back(e);
    three = (op >= 3 && op <= 6);
    md    = (op == 15 || op == 16);
    un    = (op == 17 || op == 18);
    legal = (three || md || un) && ra < nregs && rb < nregs && (!three || rc < nregs);
    if (!legal) begin
      e = blank(); e.illegal = 1; q.push_back(e);
    end else if (three) begin
      e = blank(); e.r_out = 16'(1) << rb; e.y_in = 1; q.push_back(e);
      e = blank(); e.r_out = 16'(1) << rc; e.alu_op = instr[31:27]; e.z_in = 1; q.push_back(e);
      e = blank(); e.zlo_out = 1; e.r_in = 16'(1) << ra; e.done = 1; q.push_back(e);
    end else if (md) begin
      e = blank(); e.r_out = 16'(1) << ra; e.y_in = 1; q.push_back(e);
      e = blank(); e.r_out = 16'(1) << rb; e.alu_op = instr[31:27]; e.z_in = 1; q.push_back(e);
      e = blank(); e.zlo_out = 1; e.lo_in = 1; q.push_back(e);
      e = blank(); e.zhi_out = 1; e.hi_in = 1; e.done = 1; q.push_back(e);
    end else begin
      e = blank(); e.r_out = 16'(1) << rb; e.alu_op = instr[31:27]; e.z_in = 1; q.push_back(e);
      e = blank(); e.zlo_out = 1; e.r_in = 16'(1) << ra; e.done = 1; q.push_back(e);
    end
    q.push_back(zero);
    return q;
  endfunction

  function automatic obs_t at(input obs_q_t q, input int k);
    if (k < q.size()) return q[k];
    return zero;
  endfunction

  function automatic logic [31:0] rand_legal();
    int unsigned ops[8] = '{3, 4, 5, 6, 15, 16, 17, 18};
    logic [4:0] op5;
    op5 = 5'(ops[$urandom_range(0, 7)]);
    return {op5, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 15'($urandom)};
  endfunction

  // Sample both instances mid-cycle, then set this cycle's start/mem_ready
  task automatic step(input bit start_v, input bit mr, output obs_t g16, output obs_t g8);
    @(negedge clk);
    g16 = o16;
    g8 = o8;
    start = start_v;
    mem_ready = mr;
  endtask

  // Launch one instruction and collect n cycles of both instances' outputs
  task automatic exec(input logic [31:0] instr, input int waits, input int n,
                      output obs_q_t g16, output obs_q_t g8);
    obs_t a, b;
    g16 = {};
    g8 = {};
    start = 1'b1;
    ir = instr;
    mem_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, k == 1 + waits, a, b);
      g16.push_back(a);
      g8.push_back(b);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (o16 !== zero) begin errors++; $display("FAIL reset dut16 got=%h exp=%h", o16, zero); end
    if (o8 !== zero) begin errors++; $display("FAIL reset dut8 got=%h exp=%h", o8, zero); end
    start = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    checks += 2;
    if (o16 !== zero) begin errors++; $display("FAIL reset_idle dut16 got=%h exp=%h", o16, zero); end
    if (o8 !== zero) begin errors++; $display("FAIL reset_idle dut8 got=%h exp=%h", o8, zero); end
  endtask

  task automatic test_directed();
    logic [31:0] tbl[6] = '{32'h221B8000, 32'h79888000, 32'h89288000,
                            32'hF8000000, 32'h22980000, 32'h24980000};
    obs_q_t q16, q8, g16, g8;
    int n;
    for (int i = 0; i < 6; i++) begin
      q16 = build(tbl[i], 16, 0);
      q8 = build(tbl[i], 8, 0);
      n = (q16.size() > q8.size()) ? q16.size() : q8.size();
      exec(tbl[i], 0, n, g16, g8);
      for (int k = 0; k < n; k++) begin
        checks += 2;
        if (g16[k] !== at(q16, k)) begin
          errors++; $display("FAIL directed dut16 ir=%h cyc%0d got=%h exp=%h", tbl[i], k, g16[k], at(q16, k));
        end
        if (g8[k] !== at(q8, k)) begin
          errors++; $display("FAIL directed dut8 ir=%h cyc%0d got=%h exp=%h", tbl[i], k, g8[k], at(q8, k));
        end
      end
    end
  endtask

  task automatic test_random();
    int unsigned ops[8] = '{3, 4, 5, 6, 15, 16, 17, 18};
    obs_q_t q16, q8, g16, g8;
    logic [31:0] instr;
    logic [4:0] op5;
    int sel, w, n;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      op5 = (sel < 8) ? 5'(ops[sel]) : 5'($urandom_range(0, 31));
      instr = {op5, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      w = $urandom_range(0, 4);
      q16 = build(instr, 16, w);
      q8 = build(instr, 8, w);
      n = (q16.size() > q8.size()) ? q16.size() : q8.size();
      exec(instr, w, n, g16, g8);
      for (int k = 0; k < n; k++) begin
        checks += 2;
        if (g16[k] !== at(q16, k)) begin
          errors++; $display("FAIL random dut16 ir=%h w=%0d cyc%0d got=%h exp=%h", instr, w, k, g16[k], at(q16, k));
        end
        if (g8[k] !== at(q8, k)) begin
          errors++; $display("FAIL random dut8 ir=%h w=%0d cyc%0d got=%h exp=%h", instr, w, k, g8[k], at(q8, k));
        end
      end
    end
  endtask

  task automatic test_mem_stall();
    logic [31:0] tbl[4];
    int wt[4];
    obs_q_t q16, q8, g16, g8;
    int n;
    tbl[0] = 32'h221B8000; wt[0] = 3;
    tbl[1] = 32'h89288000; wt[1] = 1000;
    tbl[2] = rand_legal(); wt[2] = 14;
    tbl[3] = rand_legal(); wt[3] = $urandom_range(5, 13);
    for (int i = 0; i < 4; i++) begin
      q16 = build(tbl[i], 16, wt[i]);
      q8 = build(tbl[i], 8, wt[i]);
      n = (q16.size() > q8.size()) ? q16.size() : q8.size();
      exec(tbl[i], wt[i], n, g16, g8);
      for (int k = 0; k < n; k++) begin
        checks += 2;
        if (g16[k] !== at(q16, k)) begin
          errors++; $display("FAIL stall dut16 w=%0d cyc%0d got=%h exp=%h", wt[i], k, g16[k], at(q16, k));
        end
        if (g8[k] !== at(q8, k)) begin
          errors++; $display("FAIL stall dut8 w=%0d cyc%0d got=%h exp=%h", wt[i], k, g8[k], at(q8, k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q_t qa, qb, ex;
    obs_t g16, g8;
    logic [31:0] ia, ib;
    int wa, wb, la;
    for (int it = 0; it < 4; it++) begin
      ia = rand_legal();
      ib = rand_legal();
      wa = $urandom_range(0, 2);
      wb = $urandom_range(0, 2);
      qa = build(ia, 16, wa);
      void'(qa.pop_back());
      la = qa.size();
      qb = build(ib, 16, wb);
      ex = qa;
      foreach (qb[j]) ex.push_back(qb[j]);
      start = 1'b1;
      ir = ia;
      mem_ready = 1'b0;
      for (int k = 0; k < ex.size(); k++) begin
        step(k == la - 1, (k == 1 + wa) || (k == la + 1 + wb), g16, g8);
        if (k == la - 1) ir = ib;
        checks += 2;
        if (g16 !== ex[k]) begin
          errors++; $display("FAIL b2b dut16 %h>%h cyc%0d got=%h exp=%h", ia, ib, k, g16, ex[k]);
        end
        if (g8 !== ex[k]) begin
          errors++; $display("FAIL b2b dut8 %h>%h cyc%0d got=%h exp=%h", ia, ib, k, g8, ex[k]);
        end
      end
    end
  endtask

  task automatic test_clr_mid();
    obs_q_t q, g16q, g8q;
    obs_t g16, g8;
    q = build(32'h221B8000, 16, 0);
    start = 1'b1;
    ir = 32'h221B8000;
    mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, k == 1, g16, g8);
      checks += 2;
      if (g16 !== q[k]) begin errors++; $display("FAIL clr_pre dut16 cyc%0d got=%h exp=%h", k, g16, q[k]); end
      if (g8 !== q[k]) begin errors++; $display("FAIL clr_pre dut8 cyc%0d got=%h exp=%h", k, g8, q[k]); end
    end
    #2 clr = 1'b0;
    #1;
    checks += 2;
    if (o16 !== zero) begin errors++; $display("FAIL clr_async dut16 got=%h exp=%h", o16, zero); end
    if (o8 !== zero) begin errors++; $display("FAIL clr_async dut8 got=%h exp=%h", o8, zero); end
    @(negedge clk);
    checks += 2;
    if (o16 !== zero) begin errors++; $display("FAIL clr_hold dut16 got=%h exp=%h", o16, zero); end
    if (o8 !== zero) begin errors++; $display("FAIL clr_hold dut8 got=%h exp=%h", o8, zero); end
    clr = 1'b1;
    q = build(32'h79888000, 16, 0);
    exec(32'h79888000, 0, q.size(), g16q, g8q);
    for (int k = 0; k < q.size(); k++) begin
      checks += 2;
      if (g16q[k] !== q[k]) begin errors++; $display("FAIL clr_after dut16 cyc%0d got=%h exp=%h", k, g16q[k], q[k]); end
      if (g8q[k] !== q[k]) begin errors++; $display("FAIL clr_after dut8 cyc%0d got=%h exp=%h", k, g8q[k], q[k]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mem_stall();
    test_back_to_back();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
